// File: rtl/terrain_carver_if.sv
// rtl/terrain_carver_if.sv - carve request and terrain RAM port bundle for terrain_carver
interface terrain_carver_if;
    logic         start;
    logic [9:0]   center_x;
    logic [9:0]   center_y;
    logic [9:0]   radius;
    logic         busy;
    logic         done;
    logic [9:0]   mem_addr;
    logic         mem_rd;
    logic [511:0] mem_rdata;
    logic         mem_wr;
    logic [511:0] mem_wdata;

    modport slave (
        input  start, center_x, center_y, radius, mem_rdata,
        output busy, done, mem_addr, mem_rd, mem_wr, mem_wdata
    );

    modport master (
        output start, center_x, center_y, radius, mem_rdata,
        input  busy, done, mem_addr, mem_rd, mem_wr, mem_wdata
    );
endinterface

// File: rtl/terrain_carver.sv
// rtl/terrain_carver.sv - carves a circular crater into column-organised terrain RAM
module terrain_carver #(
    parameter int COLS = 640,
    parameter int ROWS = 480,
    parameter int RMAX = 63
) (
    input  logic             clk,
    input  logic             reset,
    terrain_carver_if.slave  bus
);
    localparam int RW = $clog2(RMAX + 1);
    localparam int SW = 2 * RW + 2;

    typedef enum logic [2:0] {
        S_IDLE, S_CAPTURE, S_SHRINK, S_RD, S_WAIT, S_WR, S_NEXT, S_DONE
    } state_t;

    state_t          r_state, w_next;
    logic [9:0]      r_cx, r_cy, r_addr;
    logic [RW-1:0]   r_r, r_h;
    logic [RW:0]     r_dx;
    logic [SW-1:0]   r_r2;
    logic            r_side;

    logic [RW-1:0]   w_r_clamp;
    logic [SW-1:0]   w_dx_w, w_h_w, w_sq_sum;
    logic            w_shrink;
    logic [10:0]     w_p_col;
    logic            w_p_ok, w_m_ok;
    logic [9:0]      w_m_col;
    logic signed [11:0] w_lo_raw, w_hi_raw, w_lo, w_hi;
    logic [511:0]    w_mask;

    assign w_r_clamp = (bus.radius > 10'(RMAX)) ? RW'(RMAX) : bus.radius[RW-1:0];
    assign w_dx_w    = SW'(r_dx);
    assign w_h_w     = SW'(r_h);
    assign w_sq_sum  = w_dx_w * w_dx_w + w_h_w * w_h_w;
    assign w_shrink  = (w_sq_sum > r_r2);

    assign w_p_col = {1'b0, r_cx} + 11'(r_dx);
    assign w_p_ok  = (w_p_col < 11'(COLS));
    assign w_m_ok  = (r_dx != '0) && ({1'b0, r_cx} >= 11'(r_dx));
    assign w_m_col = r_cx - 10'(r_dx);

    // Row span is clipped to the screen; an empty span yields an all-zero mask.
    assign w_lo_raw = $signed({2'b00, r_cy}) - $signed(12'(r_h));
    assign w_hi_raw = $signed({2'b00, r_cy}) + $signed(12'(r_h));
    assign w_lo     = (w_lo_raw < 12'sd0) ? 12'sd0 : w_lo_raw;
    assign w_hi     = (w_hi_raw > $signed(12'(ROWS - 1))) ? $signed(12'(ROWS - 1)) : w_hi_raw;

    always_comb begin
        w_mask = '0;
        for (int i = 0; i < 512; i++) begin
            w_mask[i] = ($signed(12'(i)) >= w_lo) && ($signed(12'(i)) <= w_hi);
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (bus.start) w_next = S_CAPTURE;
            S_CAPTURE: w_next = S_SHRINK;
            S_SHRINK: begin
                if (w_shrink)    w_next = S_SHRINK;
                else if (w_p_ok) w_next = S_RD;
                else if (w_m_ok) w_next = S_RD;
                else             w_next = S_NEXT;
            end
            S_RD:      w_next = S_WAIT;
            S_WAIT:    w_next = S_WR;
            S_WR:      w_next = (!r_side && w_m_ok) ? S_RD : S_NEXT;
            S_NEXT:    w_next = (r_dx >= {1'b0, r_r}) ? S_DONE : S_SHRINK;
            S_DONE:    w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_cx    <= '0;
            r_cy    <= '0;
            r_r     <= '0;
            r_h     <= '0;
            r_dx    <= '0;
            r_r2    <= '0;
            r_side  <= 1'b0;
            r_addr  <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_cx <= bus.center_x;
                        r_cy <= bus.center_y;
                        r_r  <= w_r_clamp;
                        r_h  <= w_r_clamp;
                        r_dx <= '0;
                    end
                end
                S_CAPTURE: r_r2 <= SW'(r_r) * SW'(r_r);
                S_SHRINK: begin
                    if (w_shrink) begin
                        r_h <= r_h - 1'b1;
                    end else if (w_p_ok) begin
                        r_addr <= w_p_col[9:0];
                        r_side <= 1'b0;
                    end else if (w_m_ok) begin
                        r_addr <= w_m_col;
                        r_side <= 1'b1;
                    end
                end
                S_WR: begin
                    if (!r_side && w_m_ok) begin
                        r_addr <= w_m_col;
                        r_side <= 1'b1;
                    end
                end
                S_NEXT: r_dx <= r_dx + 1'b1;
                default: ;
            endcase
        end
    end

    assign bus.busy      = (r_state != S_IDLE) && (r_state != S_DONE);
    assign bus.done      = (r_state == S_DONE);
    assign bus.mem_rd    = (r_state == S_RD);
    assign bus.mem_wr    = (r_state == S_WR);
    assign bus.mem_addr  = r_addr;
    // Read data is consumed in the write cycle itself, so RAM output must hold after the read.
    assign bus.mem_wdata = (r_state == S_WR) ? (bus.mem_rdata & ~w_mask) : '0;
endmodule

// File: tb/tb_terrain_carver.sv
// tb/tb_terrain_carver.sv - randomized self-checking bench for terrain_carver
module tb_terrain_carver;
    localparam int COLS = 640;
    localparam int ROWS = 480;
    localparam int RMAX = 63;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    terrain_carver_if bus();
    terrain_carver #(.COLS(COLS), .ROWS(ROWS), .RMAX(RMAX)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    logic [511:0] ram      [COLS];
    logic [511:0] fill_src [COLS];
    logic [511:0] model    [COLS];
    logic         fill_req = 1'b0;

    // Synchronous RAM whose read register holds until the next read.
    always @(posedge clk) begin
        if (fill_req) begin
            for (int c = 0; c < COLS; c++) ram[c] <= fill_src[c];
        end else begin
            if (bus.mem_rd && bus.mem_addr < COLS) bus.mem_rdata <= ram[bus.mem_addr];
            if (bus.mem_wr && bus.mem_addr < COLS) ram[bus.mem_addr] <= bus.mem_wdata;
        end
    end

    int n_wr = 0;
    int bad_acc = 0;
    int wr_addrs[$];
    always @(negedge clk) begin
        if (reset) begin
            if (bus.mem_wr) begin
                n_wr++;
                wr_addrs.push_back(int'(bus.mem_addr));
                if (bus.mem_addr >= COLS) bad_acc++;
            end
            if (bus.mem_rd && bus.mem_addr >= COLS) bad_acc++;
            if (bus.mem_rd && bus.mem_wr) bad_acc++;
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic fill(input bit rnd);
        logic [511:0] w;
        for (int c = 0; c < COLS; c++) begin
            w = '1;
            if (rnd) for (int k = 0; k < 16; k++) w[k*32 +: 32] = $urandom;
            fill_src[c] = w;
            model[c]    = w;
        end
        fill_req = 1'b1;
        @(posedge clk); #1;
        fill_req = 1'b0;
    endtask

    // Reference: every pixel within the clamped circle is cleared.
    task automatic model_carve(input int cx, input int cy, input int r);
        int rr;
        rr = (r > RMAX) ? RMAX : r;
        for (int c = cx - rr; c <= cx + rr; c++) begin
            if (c >= 0 && c < COLS) begin
                for (int y = 0; y < ROWS; y++) begin
                    if ((c - cx) * (c - cx) + (y - cy) * (y - cy) <= rr * rr) model[c][y] = 1'b0;
                end
            end
        end
    endtask

    function automatic int expected_writes(input int cx, input int r);
        int rr, n;
        rr = (r > RMAX) ? RMAX : r;
        n = 0;
        for (int c = cx - rr; c <= cx + rr; c++) if (c >= 0 && c < COLS) n++;
        return n;
    endfunction

    function automatic int mem_diff();
        int n;
        n = 0;
        for (int c = 0; c < COLS; c++) if (ram[c] !== model[c]) n++;
        return n;
    endfunction

    task automatic start_carve(input int cx, input int cy, input int r);
        @(posedge clk); #1;
        bus.start    = 1'b1;
        bus.center_x = 10'(cx);
        bus.center_y = 10'(cy);
        bus.radius   = 10'(r);
        @(posedge clk); #1;
        bus.start = 1'b0;
        check("busy_rise", bus.busy, 1);
    endtask

    task automatic wait_done(output int lat);
        lat = 1;
        while (bus.done !== 1'b1 && lat < 5000) begin
            @(posedge clk); #1;
            lat++;
        end
        check("done_seen", bus.done, 1);
        check("busy_at_done", bus.busy, 0);
        @(posedge clk); #1;
        check("done_pulse", bus.done, 0);
    endtask

    task automatic carve(input int cx, input int cy, input int r, output int lat);
        start_carve(cx, cy, r);
        wait_done(lat);
        model_carve(cx, cy, r);
    endtask

    initial begin
        int lat, base, bad0, amin, amax, cx, cy, r, guard;
        logic [511:0] w;

        bus.start = 1'b0; bus.center_x = '0; bus.center_y = '0; bus.radius = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_rd", bus.mem_rd, 0);
        check("rst_wr", bus.mem_wr, 0);
        check("rst_addr", bus.mem_addr, 0);
        check("rst_wdata", bus.mem_wdata, 0);
        reset = 1'b1;
        bad0 = bad_acc;

        // Single pixel
        fill(1'b0);
        base = n_wr;
        carve(100, 200, 0, lat);
        check("px_latency", lat, 7);
        check("px_writes", n_wr - base, 1);
        check("px_addr", wr_addrs[base], 100);
        w = '1; w[200] = 1'b0;
        check("px_word", ram[100], w);
        check("px_mem", mem_diff(), 0);

        // r=2 crater
        fill(1'b0);
        base = n_wr;
        carve(100, 200, 2, lat);
        check("r2_writes", n_wr - base, 5);
        w = '1; for (int y = 198; y <= 202; y++) w[y] = 1'b0;
        check("r2_col100", ram[100], w);
        w = '1; for (int y = 199; y <= 201; y++) w[y] = 1'b0;
        check("r2_col99", ram[99], w);
        w = '1; w[200] = 1'b0;
        check("r2_col102", ram[102], w);
        check("r2_mem", mem_diff(), 0);

        // Left and right edge clipping
        fill(1'b0);
        base = n_wr;
        carve(0, 10, 2, lat);
        check("edge_l_writes", n_wr - base, 3);
        amax = 0;
        for (int i = base; i < n_wr; i++) if (wr_addrs[i] > amax) amax = wr_addrs[i];
        check("edge_l_maxaddr", amax, 2);
        check("edge_l_mem", mem_diff(), 0);
        base = n_wr;
        carve(639, 10, 2, lat);
        check("edge_r_writes", n_wr - base, 3);
        amin = 1023;
        for (int i = base; i < n_wr; i++) if (wr_addrs[i] < amin) amin = wr_addrs[i];
        check("edge_r_minaddr", amin, 637);
        check("edge_r_mem", mem_diff(), 0);

        // Row clipping at top and bottom
        fill(1'b0);
        carve(50, 1, 3, lat);
        w = '1; for (int y = 0; y <= 4; y++) w[y] = 1'b0;
        check("row_top", ram[50], w);
        fill(1'b0);
        carve(50, 479, 3, lat);
        w = '1; for (int y = 476; y <= 479; y++) w[y] = 1'b0;
        check("row_bot", ram[50], w);
        check("row_mem", mem_diff(), 0);

        // Second start while busy is ignored
        fill(1'b0);
        base = n_wr;
        start_carve(300, 100, 4);
        repeat (3) @(posedge clk);
        #1;
        bus.start = 1'b1; bus.center_x = 10'd500; bus.center_y = 10'd300; bus.radius = 10'd5;
        @(posedge clk); #1;
        bus.start = 1'b0;
        wait_done(lat);
        model_carve(300, 100, 4);
        check("busy_writes", n_wr - base, 9);
        check("busy_mem", mem_diff(), 0);

        // Reset during WAIT of the third column (col 99)
        fill(1'b0);
        base = n_wr;
        start_carve(100, 200, 2);
        guard = 0;
        while (!(bus.mem_rd && (n_wr - base) == 2) && guard < 200) begin
            @(posedge clk); #1;
            guard++;
        end
        check("rst_mid_reach", guard < 200, 1);
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        check("mid_busy", bus.busy, 0);
        check("mid_rd", bus.mem_rd, 0);
        check("mid_wr", bus.mem_wr, 0);
        check("mid_addr", bus.mem_addr, 0);
        check("mid_wdata", bus.mem_wdata, 0);
        model_carve(100, 200, 2);
        model[99] = '1; model[98] = '1; model[102] = '1;
        check("mid_col99", ram[99], {512{1'b1}});
        check("mid_mem", mem_diff(), 0);
        @(posedge clk); #1;
        reset = 1'b1;
        carve(100, 200, 2, lat);
        check("post_rst_mem", mem_diff(), 0);

        // Randomized craters over random terrain
        for (int t = 0; t < 12; t++) begin
            fill(1'b1);
            cx = $urandom_range(700);
            cy = $urandom_range(540);
            r  = $urandom_range(80);
            base = n_wr;
            carve(cx, cy, r, lat);
            check($sformatf("rnd%0d_writes", t), n_wr - base, expected_writes(cx, r));
            check($sformatf("rnd%0d_mem", t), mem_diff(), 0);
        end

        check("bad_access", bad_acc - bad0, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
